// File: rtl/sdram_ctrl.sv
// SDRAM controller sequencing core: power-up init, then refresh/write/read arbitration.
// Drives state and cycle-count buses to the downstream command encoder.
module sdram_ctrl #(
  parameter int unsigned T_POWERUP  = 20000,
  parameter int unsigned T_RP       = 3,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned T_MRD      = 3,
  parameter int unsigned T_RCD      = 3,
  parameter int unsigned CL         = 3,
  parameter int unsigned T_DAL      = 5,
  parameter int unsigned REF_PERIOD = 780
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        sdram_wr_req,
  input  logic        sdram_rd_req,
  input  logic [8:0]  sdwr_bytes,
  input  logic [8:0]  sdrd_bytes,
  output logic [3:0]  init_state,
  output logic [3:0]  work_state,
  output logic [15:0] cnt_clk,
  output logic        sys_r_wn,
  output logic        sdram_init_done,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic        sdram_busy
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned LEN_W = 10;
  localparam int unsigned REF_W = 10;

  typedef enum logic [3:0] {
    I_NOP, I_PRECHARGE, I_TRP, I_AUTO_REFRESH1, I_TRF1,
    I_AUTO_REFRESH2, I_TRF2, I_MRS, I_TMRD, I_DONE
  } init_e;

  typedef enum logic [3:0] {
    W_IDLE, W_ACTIVE, W_TRCD, W_READ, W_CL, W_RD,
    W_WRITE, W_WD, W_TDAL, W_AR, W_TRFC
  } work_e;

  init_e             init_q, i_next;
  work_e             work_q, w_next;
  logic [CNT_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  burst_len;
  logic [REF_W-1:0]  ref_cnt;
  logic              ref_pend;
  logic              grant_wr, grant_rd;
  logic              state_chg;

  // Init sequence: each state of N cycles exits when cnt_q = N-1
  always_comb begin
    i_next = init_q;
    case (init_q)
      I_NOP:           if (cnt_q == CNT_W'(T_POWERUP - 1)) i_next = I_PRECHARGE;
      I_PRECHARGE:     i_next = I_TRP;
      I_TRP:           if (cnt_q == CNT_W'(T_RP - 2)) i_next = I_AUTO_REFRESH1;
      I_AUTO_REFRESH1: i_next = I_TRF1;
      I_TRF1:          if (cnt_q == CNT_W'(T_RFC - 2)) i_next = I_AUTO_REFRESH2;
      I_AUTO_REFRESH2: i_next = I_TRF2;
      I_TRF2:          if (cnt_q == CNT_W'(T_RFC - 2)) i_next = I_MRS;
      I_MRS:           i_next = I_TMRD;
      I_TMRD:          if (cnt_q == CNT_W'(T_MRD - 2)) i_next = I_DONE;
      I_DONE:          i_next = I_DONE;
      default:         i_next = I_NOP;
    endcase
  end

  // Work FSM with refresh > write > read priority in idle
  always_comb begin
    w_next   = work_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (init_q == I_DONE) begin
      case (work_q)
        W_IDLE: begin
          if (ref_pend) begin
            w_next = W_AR;
          end else if (sdram_wr_req) begin
            w_next   = W_ACTIVE;
            grant_wr = 1'b1;
          end else if (sdram_rd_req) begin
            w_next   = W_ACTIVE;
            grant_rd = 1'b1;
          end
        end
        W_AR:     w_next = W_TRFC;
        W_TRFC:   if (cnt_q == CNT_W'(T_RFC - 2)) w_next = W_IDLE;
        W_ACTIVE: w_next = W_TRCD;
        W_TRCD:   if (cnt_q == CNT_W'(T_RCD - 2)) w_next = sys_r_wn ? W_WRITE : W_READ;
        W_WRITE:  w_next = (burst_len == LEN_W'(1)) ? W_TDAL : W_WD;
        W_WD:     if (cnt_q == CNT_W'(burst_len) - CNT_W'(2)) w_next = W_TDAL;
        W_TDAL:   if (cnt_q == CNT_W'(T_DAL - 1)) w_next = W_IDLE;
        W_READ:   w_next = W_CL;
        W_CL:     if (cnt_q == CNT_W'(CL - 2)) w_next = W_RD;
        W_RD:     if (cnt_q == CNT_W'(burst_len) - CNT_W'(1)) w_next = W_IDLE;
        default:  w_next = W_IDLE;
      endcase
    end
  end

  assign state_chg = (i_next != init_q) || (w_next != work_q);

  // All state and handshakes registered; acks track the next work state so they align with it
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      init_q          <= I_NOP;
      work_q          <= W_IDLE;
      cnt_q           <= '0;
      sys_r_wn        <= 1'b1;
      burst_len       <= LEN_W'(1);
      sdram_init_done <= 1'b0;
      sdram_wr_ack    <= 1'b0;
      sdram_rd_ack    <= 1'b0;
      sdram_busy      <= 1'b1;
      ref_cnt         <= '0;
      ref_pend        <= 1'b0;
    end else begin
      init_q <= i_next;
      work_q <= w_next;
      if (state_chg)
        cnt_q <= '0;
      else if (cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
      if (grant_wr) begin
        sys_r_wn  <= 1'b1;
        burst_len <= {(sdwr_bytes == 9'd0), sdwr_bytes};
      end else if (grant_rd) begin
        sys_r_wn  <= 1'b0;
        burst_len <= {(sdrd_bytes == 9'd0), sdrd_bytes};
      end
      sdram_init_done <= (i_next == I_DONE);
      sdram_wr_ack    <= (w_next == W_WRITE) || (w_next == W_WD);
      sdram_rd_ack    <= (w_next == W_RD);
      sdram_busy      <= !(sdram_init_done && (w_next == W_IDLE));
      if (init_q == I_DONE) begin
        if (ref_cnt == REF_W'(REF_PERIOD - 1)) begin
          ref_cnt  <= '0;
          ref_pend <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + REF_W'(1);
        end
      end
      // Entering refresh consumes the pending request, absorbing a coincident expiry
      if (w_next == W_AR)
        ref_pend <= 1'b0;
    end
  end

  assign init_state = init_q;
  assign work_state = work_q;
  assign cnt_clk    = cnt_q;

endmodule
